// File: rtl/pixel_stream_adapter.sv
// Pixel stream adapter: buffers an upstream pixel stream in a small FIFO and
// presents it to a DVI encoder, locking the stream's sof marker to raster position (0,0).
module pixel_stream_adapter #(
    parameter int H_ACTIVE_PIXELS = 640,
    parameter int V_ACTIVE_LINES  = 480,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic        clk_pix,
    input  logic        rst_n_pix,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_data,
    input  logic        in_sof,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    input  logic        rgb_rdy,
    output logic        locked,
    output logic        err,
    output logic [7:0]  err_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int XW = (H_ACTIVE_PIXELS > 1) ? $clog2(H_ACTIVE_PIXELS) : 1;
    localparam int YW = (V_ACTIVE_LINES > 1) ? $clog2(V_ACTIVE_LINES) : 1;
    localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE_PIXELS - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE_LINES - 1);
    localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

    typedef enum logic {
        SYNC,
        LOCKED
    } state_t;

    state_t        state;
    logic [24:0]   mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [XW-1:0] pos_x;
    logic [YW-1:0] pos_y;

    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic        present;
    logic        fail;
    logic [24:0] head;
    logic        head_sof;
    logic        at_origin;
    logic        aligned;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready  = !full;
    assign push      = in_valid && !full;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign head_sof  = head[24];
    assign at_origin = (pos_x == '0) && (pos_y == '0);
    assign aligned   = !empty && head_sof && at_origin;

    always_comb begin
        pop     = 1'b0;
        present = 1'b0;
        fail    = 1'b0;
        case (state)
            SYNC: begin
                if (aligned) begin
                    present = 1'b1;
                    pop     = rgb_rdy;
                end else if (!empty && !head_sof) begin
                    pop = 1'b1;
                end
            end
            LOCKED: begin
                present = !empty && (head_sof == at_origin);
                if (rgb_rdy) begin
                    pop  = present;
                    fail = !present;
                end
            end
        endcase
    end

    assign {r, g, b} = present ? head[23:0] : 24'h0;

    always_ff @(posedge clk_pix) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {in_sof, in_data};
        end
    end

    always_ff @(posedge clk_pix or negedge rst_n_pix) begin
        if (!rst_n_pix) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Raster position tracks the encoder's consumption, whether locked or not.
    always_ff @(posedge clk_pix or negedge rst_n_pix) begin
        if (!rst_n_pix) begin
            pos_x <= '0;
            pos_y <= '0;
        end else if (rgb_rdy) begin
            if (pos_x == X_LAST) begin
                pos_x <= '0;
                pos_y <= (pos_y == Y_LAST) ? '0 : pos_y + YW'(1);
            end else begin
                pos_x <= pos_x + XW'(1);
            end
        end
    end

    always_ff @(posedge clk_pix or negedge rst_n_pix) begin
        if (!rst_n_pix) begin
            state     <= SYNC;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_count <= 8'd0;
        end else begin
            err <= fail;
            if (fail && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
            case (state)
                SYNC: begin
                    if (aligned && rgb_rdy) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (fail) begin
                        state  <= SYNC;
                        locked <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_stream_adapter.sv
// Directed testbench for pixel_stream_adapter with a 4x2 raster and a 4-entry FIFO.
module tb_pixel_stream_adapter;

    logic        clk_pix = 1'b0;
    logic        rst_n_pix = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_data = 24'h0;
    logic        in_sof = 1'b0;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        rgb_rdy = 1'b0;
    logic        locked;
    logic        err;
    logic [7:0]  err_count;
    logic [23:0] rgb;

    int vectors = 0;
    int miscompares = 0;

    assign rgb = {r, g, b};

    pixel_stream_adapter #(
        .H_ACTIVE_PIXELS(4),
        .V_ACTIVE_LINES (2),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk_pix  (clk_pix),
        .rst_n_pix(rst_n_pix),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sof   (in_sof),
        .r        (r),
        .g        (g),
        .b        (b),
        .rgb_rdy  (rgb_rdy),
        .locked   (locked),
        .err      (err),
        .err_count(err_count)
    );

    always #5 clk_pix = ~clk_pix;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [23:0] pix(input int i);
        logic [7:0] v;
        v = i[7:0];
        return {v, v ^ 8'h5A, v + 8'h80};
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
    task automatic cyc(input logic v, input logic s, input logic [23:0] d, input logic rdy);
        @(negedge clk_pix);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        rgb_rdy  = rdy;
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk_pix);
        rst_n_pix = 1'b0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_data   = 24'h0;
        rgb_rdy   = 1'b0;
        repeat (2) @(negedge clk_pix);
        rst_n_pix = 1'b1;
    endtask

    task automatic test_reset();
        reset_dut();
        cyc(0, 0, 24'h0, 0);
        vectors++; if (locked !== 1'b0) begin $display("[TB] FAIL reset_locked: got %b expected 0", locked); miscompares++; end
        vectors++; if (err !== 1'b0) begin $display("[TB] FAIL reset_err: got %b expected 0", err); miscompares++; end
        vectors++; if (err_count !== 8'd0) begin $display("[TB] FAIL reset_err_count: got %0d expected 0", err_count); miscompares++; end
        vectors++; if (in_ready !== 1'b1) begin $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); miscompares++; end
        vectors++; if (rgb !== 24'h0) begin $display("[TB] FAIL reset_rgb: got %h expected 000000", rgb); miscompares++; end
    endtask

    task automatic test_stream();
        int pushed = 0;
        int consumed = 0;
        int cycle = 0;
        logic rdy;
        logic v;
        reset_dut();
        while (consumed < 24) begin
            rdy = (cycle >= 4);
            v   = (pushed < 24);
            cyc(v, (pushed % 8) == 0, pix(pushed % 8), rdy);
            if (cycle < 4) begin
                vectors++; if (in_ready !== 1'b1) begin $display("[TB] FAIL stream_fill_ready c%0d: got %b expected 1", cycle, in_ready); miscompares++; end
            end
            if (cycle == 4) begin
                vectors++; if (in_ready !== 1'b0) begin $display("[TB] FAIL stream_full: got %b expected 0", in_ready); miscompares++; end
                vectors++; if (locked !== 1'b0) begin $display("[TB] FAIL stream_prelock: got %b expected 0", locked); miscompares++; end
            end
            if (cycle > 4) begin
                vectors++; if (locked !== 1'b1) begin $display("[TB] FAIL stream_locked c%0d: got %b expected 1", cycle, locked); miscompares++; end
            end
            if (rdy) begin
                vectors++; if (rgb !== pix(consumed % 8)) begin $display("[TB] FAIL stream_rgb #%0d: got %h expected %h", consumed, rgb, pix(consumed % 8)); miscompares++; end
                consumed++;
            end
            if (v && in_ready) pushed++;
            cycle++;
        end
        cyc(0, 0, 24'h0, 0);
        vectors++; if (locked !== 1'b1) begin $display("[TB] FAIL stream_end_locked: got %b expected 1", locked); miscompares++; end
        vectors++; if (err_count !== 8'd0) begin $display("[TB] FAIL stream_err_count: got %0d expected 0", err_count); miscompares++; end
        vectors++; if (pushed !== 24) begin $display("[TB] FAIL stream_pushed: got %0d expected 24", pushed); miscompares++; end
    endtask

    task automatic test_resync_discard();
        reset_dut();
        cyc(1, 0, 24'hAA0001, 0);
        cyc(1, 0, 24'hAA0002, 0);
        vectors++; if (rgb !== 24'h0) begin $display("[TB] FAIL discard_rgb1: got %h expected 000000", rgb); miscompares++; end
        cyc(1, 0, 24'hAA0003, 0);
        vectors++; if (rgb !== 24'h0) begin $display("[TB] FAIL discard_rgb2: got %h expected 000000", rgb); miscompares++; end
        cyc(1, 1, pix(0), 0);
        vectors++; if (rgb !== 24'h0) begin $display("[TB] FAIL discard_rgb3: got %h expected 000000", rgb); miscompares++; end
        for (int i = 1; i < 4; i++) begin
            cyc(1, 0, pix(i), 0);
            vectors++; if (in_ready !== 1'b1) begin $display("[TB] FAIL discard_ready %0d: got %b expected 1", i, in_ready); miscompares++; end
            vectors++; if (rgb !== pix(0)) begin $display("[TB] FAIL discard_head %0d: got %h expected %h", i, rgb, pix(0)); miscompares++; end
        end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 24'h0, 1);
            if (i == 0) begin
                vectors++; if (in_ready !== 1'b0) begin $display("[TB] FAIL discard_full: got %b expected 0", in_ready); miscompares++; end
                vectors++; if (locked !== 1'b0) begin $display("[TB] FAIL discard_prelock: got %b expected 0", locked); miscompares++; end
            end else begin
                vectors++; if (locked !== 1'b1) begin $display("[TB] FAIL discard_locked %0d: got %b expected 1", i, locked); miscompares++; end
            end
            vectors++; if (rgb !== pix(i)) begin $display("[TB] FAIL discard_out %0d: got %h expected %h", i, rgb, pix(i)); miscompares++; end
        end
        cyc(0, 0, 24'h0, 0);
        vectors++; if (err_count !== 8'd0) begin $display("[TB] FAIL discard_err_count: got %0d expected 0", err_count); miscompares++; end
    endtask

    task automatic test_underrun();
        reset_dut();
        for (int i = 0; i < 4; i++) cyc(1, i == 0, pix(i), 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 24'h0, 1);
            vectors++; if (rgb !== pix(i)) begin $display("[TB] FAIL underrun_pre %0d: got %h expected %h", i, rgb, pix(i)); miscompares++; end
        end
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 24'h0, 1);
            vectors++; if (rgb !== 24'h0) begin $display("[TB] FAIL underrun_rgb %0d: got %h expected 000000", k, rgb); miscompares++; end
            vectors++; if (err !== (k == 1)) begin $display("[TB] FAIL underrun_err %0d: got %b expected %b", k, err, (k == 1)); miscompares++; end
            vectors++; if (locked !== (k == 0)) begin $display("[TB] FAIL underrun_locked %0d: got %b expected %b", k, locked, (k == 0)); miscompares++; end
        end
        vectors++; if (err_count !== 8'd1) begin $display("[TB] FAIL underrun_err_count: got %0d expected 1", err_count); miscompares++; end
        for (int i = 0; i < 4; i++) cyc(1, i == 0, pix(16 + i), 0);
        for (int k = 0; k < 7; k++) begin
            cyc(0, 0, 24'h0, 1);
            vectors++; if (rgb !== 24'h0) begin $display("[TB] FAIL underrun_wait %0d: got %h expected 000000", k, rgb); miscompares++; end
        end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 24'h0, 1);
            vectors++; if (rgb !== pix(16 + i)) begin $display("[TB] FAIL underrun_relock %0d: got %h expected %h", i, rgb, pix(16 + i)); miscompares++; end
        end
        cyc(0, 0, 24'h0, 0);
        vectors++; if (locked !== 1'b1) begin $display("[TB] FAIL underrun_final_locked: got %b expected 1", locked); miscompares++; end
        vectors++; if (err_count !== 8'd1) begin $display("[TB] FAIL underrun_final_count: got %0d expected 1", err_count); miscompares++; end
    endtask

    task automatic test_sof_mismatch();
        reset_dut();
        cyc(1, 1, pix(0), 0);
        cyc(1, 0, pix(1), 0);
        cyc(1, 1, pix(2), 0);
        cyc(1, 0, pix(3), 0);
        cyc(0, 0, 24'h0, 1);
        vectors++; if (rgb !== pix(0)) begin $display("[TB] FAIL mismatch_c1: got %h expected %h", rgb, pix(0)); miscompares++; end
        cyc(0, 0, 24'h0, 1);
        vectors++; if (rgb !== pix(1)) begin $display("[TB] FAIL mismatch_c2: got %h expected %h", rgb, pix(1)); miscompares++; end
        cyc(0, 0, 24'h0, 1);
        vectors++; if (rgb !== 24'h0) begin $display("[TB] FAIL mismatch_c3_rgb: got %h expected 000000", rgb); miscompares++; end
        vectors++; if (locked !== 1'b1) begin $display("[TB] FAIL mismatch_c3_locked: got %b expected 1", locked); miscompares++; end
        cyc(0, 0, 24'h0, 1);
        vectors++; if (err !== 1'b1) begin $display("[TB] FAIL mismatch_err: got %b expected 1", err); miscompares++; end
        vectors++; if (locked !== 1'b0) begin $display("[TB] FAIL mismatch_unlock: got %b expected 0", locked); miscompares++; end
        vectors++; if (err_count !== 8'd1) begin $display("[TB] FAIL mismatch_count: got %0d expected 1", err_count); miscompares++; end
        vectors++; if (rgb !== 24'h0) begin $display("[TB] FAIL mismatch_c4_rgb: got %h expected 000000", rgb); miscompares++; end
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 24'h0, 1);
            vectors++; if (rgb !== 24'h0) begin $display("[TB] FAIL mismatch_hold %0d: got %h expected 000000", k, rgb); miscompares++; end
            vectors++; if (err !== 1'b0) begin $display("[TB] FAIL mismatch_err_width %0d: got %b expected 0", k, err); miscompares++; end
        end
        cyc(0, 0, 24'h0, 1);
        vectors++; if (rgb !== pix(2)) begin $display("[TB] FAIL mismatch_relock: got %h expected %h", rgb, pix(2)); miscompares++; end
        cyc(0, 0, 24'h0, 1);
        vectors++; if (rgb !== pix(3)) begin $display("[TB] FAIL mismatch_next: got %h expected %h", rgb, pix(3)); miscompares++; end
        cyc(0, 0, 24'h0, 0);
        vectors++; if (locked !== 1'b1) begin $display("[TB] FAIL mismatch_final_locked: got %b expected 1", locked); miscompares++; end
        vectors++; if (err_count !== 8'd1) begin $display("[TB] FAIL mismatch_final_count: got %0d expected 1", err_count); miscompares++; end
    endtask

    task automatic test_saturation();
        int pulses = 0;
        reset_dut();
        for (int n = 1; n <= 300; n++) begin
            cyc(1, 1, pix(5), 0);
            for (int k = 0; k < 8; k++) begin
                cyc(0, 0, 24'h0, 1);
                if (err === 1'b1) pulses++;
            end
            if (n == 1 || n == 254 || n == 255 || n == 300) begin
                vectors++;
                if (err_count !== ((n > 255) ? 8'd255 : 8'(n))) begin
                    $display("[TB] FAIL sat_count n=%0d: got %0d expected %0d", n, err_count, (n > 255) ? 255 : n);
                    miscompares++;
                end
            end
        end
        vectors++; if (pulses !== 300) begin $display("[TB] FAIL sat_pulses: got %0d expected 300", pulses); miscompares++; end
    endtask

    task automatic test_reset_midline();
        for (int i = 0; i < 4; i++) cyc(1, i == 0, pix(i), 0);
        cyc(0, 0, 24'h0, 1);
        vectors++; if (rgb !== pix(0)) begin $display("[TB] FAIL midrst_first: got %h expected %h", rgb, pix(0)); miscompares++; end
        cyc(0, 0, 24'h0, 0);
        vectors++; if (locked !== 1'b1) begin $display("[TB] FAIL midrst_locked: got %b expected 1", locked); miscompares++; end
        #2;
        rst_n_pix = 1'b0;
        #1;
        vectors++; if (locked !== 1'b0) begin $display("[TB] FAIL midrst_async_locked: got %b expected 0", locked); miscompares++; end
        vectors++; if (err_count !== 8'd0) begin $display("[TB] FAIL midrst_async_count: got %0d expected 0", err_count); miscompares++; end
        vectors++; if (err !== 1'b0) begin $display("[TB] FAIL midrst_async_err: got %b expected 0", err); miscompares++; end
        vectors++; if (rgb !== 24'h0) begin $display("[TB] FAIL midrst_async_rgb: got %h expected 000000", rgb); miscompares++; end
        @(negedge clk_pix);
        rst_n_pix = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0, 24'h0, 1);
            vectors++; if (rgb !== 24'h0) begin $display("[TB] FAIL midrst_stale %0d: got %h expected 000000", k, rgb); miscompares++; end
            vectors++; if (in_ready !== 1'b1) begin $display("[TB] FAIL midrst_ready %0d: got %b expected 1", k, in_ready); miscompares++; end
        end
        cyc(1, 1, pix(20), 0);
        cyc(0, 0, 24'h0, 1);
        vectors++; if (rgb !== pix(20)) begin $display("[TB] FAIL midrst_relock: got %h expected %h", rgb, pix(20)); miscompares++; end
        cyc(0, 0, 24'h0, 0);
        vectors++; if (locked !== 1'b1) begin $display("[TB] FAIL midrst_final_locked: got %b expected 1", locked); miscompares++; end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_resync_discard();
        test_underrun();
        test_sof_mismatch();
        test_saturation();
        test_reset_midline();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pixel_stream_adapter.md
PIXEL_STREAM_ADAPTER -- requirements
Module: pixel_stream_adapter

Interface
REQ-001 Parameter H_ACTIVE_PIXELS, default 640, active pixels per line.
REQ-002 Parameter V_ACTIVE_LINES, default 480, active lines per frame.
REQ-003 Parameter FIFO_DEPTH, default 16, FIFO entries; power of 2, >= 4.
REQ-004 clk_pix  input  1  pixel clock; all logic in this single domain.
REQ-005 rst_n_pix  input  1  reset: asynchronous, active-low.
REQ-006 in_valid  input  1  upstream pixel valid.
REQ-007 in_ready  output  1  adapter accepts pixel this cycle.
REQ-008 in_data  input  24  pixel {r[23:16], g[15:8], b[7:0]}.
REQ-009 in_sof  input  1  pixel is first pixel (x=0, y=0) of a frame.
REQ-010 r, g, b  output  8 each  pixel presented to the DVI encoder.
REQ-011 rgb_rdy  input  1  encoder consumes r/g/b this cycle.
REQ-012 locked  output  1  high in state LOCKED.
REQ-013 err  output  1  one-cycle pulse on loss of lock.
REQ-014 err_count  output  8  saturating count of lock losses.

Function
REQ-015 FIFO: synchronous, FIFO_DEPTH entries of 25 bits {sof, data}; push when in_valid && in_ready.
REQ-016 in_ready SHALL equal !full; no push when full, regardless of pop that cycle.
REQ-017 Head entry read combinationally; pushed pixel visible at head no earlier than the next cycle (push into empty FIFO: not poppable same cycle).
REQ-018 Position counters pos_x (0..H_ACTIVE_PIXELS-1), pos_y (0..V_ACTIVE_LINES-1) advance on every rgb_rdy cycle, in all states; pos_x wraps to 0 and increments pos_y; (H-1, V-1) wraps to (0,0).
REQ-019 States: SYNC, LOCKED; reset state SYNC.
REQ-020 SYNC: when FIFO non-empty and head sof=0, pop head (one per cycle, independent of rgb_rdy).
REQ-021 SYNC: "aligned" = non-empty && head sof=1 && pos_x=0 && pos_y=0.
REQ-022 SYNC, aligned && rgb_rdy: present head, pop, go LOCKED.
REQ-023 SYNC, head sof=1 and not at (0,0): hold head, no pop.
REQ-024 r/g/b = head data when (LOCKED and non-empty) or aligned; else 0.
REQ-025 LOCKED, rgb_rdy, non-empty, head sof equals (pos_x=0 && pos_y=0): present head, pop, stay LOCKED.
REQ-026 LOCKED, rgb_rdy, FIFO empty (underrun): r/g/b=0, go SYNC, err pulse.
REQ-027 LOCKED, rgb_rdy, head sof mismatches position: r/g/b=0, no pop, go SYNC, err pulse.
REQ-028 LOCKED without rgb_rdy: no pop, no state change, even if empty.
REQ-029 err_count increments on each err pulse, saturates at 255.
REQ-030 err asserts in the cycle following the failing rgb_rdy cycle (registered), width exactly 1 cycle.
REQ-031 Pops only as defined above; push and pop in same cycle leave occupancy unchanged.

Reset
REQ-032 Async assertion of rst_n_pix: state SYNC, FIFO empty, pos_x=pos_y=0, err=0, err_count=0, locked=0, r/g/b=0, in_ready=1 after deassertion.
REQ-033 Reset mid-frame discards FIFO contents; adapter relocks only on a new sof at position (0,0).
REQ-034 Reset deassertion synchronised externally; block requires no extra cycles beyond first clk_pix edge.

Verification (bench parameters H=4, V=2, DEPTH=4)
REQ-035 Stream 3 frames of 8 pixels, data=index, sof on first; rgb_rdy every cycle after FIFO full -> locked=1 from first (0,0), outputs 0..7 repeating, err_count=0.
REQ-036 Push 3 non-sof pixels then sof frame while in SYNC -> 3 pixels discarded in 3 cycles, lock at next (0,0), first output = sof pixel data.
REQ-037 Locked, stop in_valid for 5 rgb_rdy cycles -> r/g/b=0 at first empty consume, err single pulse, err_count=1, locked=0, relock at next frame start.
REQ-038 Locked, inject sof at pos_x=2 -> no pop, r/g/b=0, state SYNC, err_count+1; sof held until (0,0) then relock.
REQ-039 Force 300 underruns -> err_count saturates at 255, no wrap.
REQ-040 Assert rst_n_pix with FIFO 3/4 full mid-line -> all outputs per REQ-032 immediately; in_ready=1 next cycle; old pixels never appear.
